wired_bus_arbiter: RTL

WIRED_BUS_ARBITER -- requirements
Module: wired_bus_arbiter

---
 rtl/wired_bus_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wired_bus_arbiter.sv
// rtl/wired_bus_arbiter.sv - two-port round-robin arbiter onto a single downstream bus
module wired_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_paddr,
  input  logic [1:0]        r0_size,
  input  logic [1:0]        r0_type,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_paddr,
  input  logic [1:0]        r1_size,
  input  logic [1:0]        r1_type,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_paddr,
  output logic [1:0]        m_size,
  output logic [1:0]        m_type,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              m_owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state;
  state_t            state_next;
  logic              ptr;
  logic              owner;
  logic              grant;
  logic              grant_id;
  logic              complete;
  logic [ADDR_W-1:0] paddr_q;
  logic [1:0]        size_q;
  logic [1:0]        type_q;
  logic [DATA_W-1:0] wdata_q;

  // Round-robin pick: on a tie the port that was not granted last wins.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (state == S_IDLE) begin
      if (r0_valid && r1_valid) begin
        grant    = 1'b1;
        grant_id = ~ptr;
      end else if (r0_valid) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (r1_valid) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winner's request so later requester activity cannot disturb the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= 1'b1;
      owner   <= 1'b0;
      paddr_q <= '0;
      size_q  <= '0;
      type_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      ptr     <= grant_id;
      owner   <= grant_id;
      paddr_q <= grant_id ? r1_paddr : r0_paddr;
      size_q  <= grant_id ? r1_size  : r0_size;
      type_q  <= grant_id ? r1_type  : r0_type;
      wdata_q <= grant_id ? r1_wdata : r0_wdata;
    end
  end

  // Next-state and handshake outputs; m_done only counts while waiting.
  always_comb begin
    state_next = state;
    m_valid    = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        m_valid = 1'b1;
        if (m_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (m_done) begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign m_paddr = paddr_q;
  assign m_size  = size_q;
  assign m_type  = type_q;
  assign m_wdata = wdata_q;
  assign m_owner = (state != S_IDLE) ? owner : 1'b0;

  // A flushed requester (valid dropped) does not see its completion.
  assign r0_ready = complete && !owner && r0_valid;
  assign r1_ready = complete && owner && r1_valid;
  assign r0_rdata = r0_ready ? m_rdata : '0;
  assign r1_rdata = r1_ready ? m_rdata : '0;

endmodule
